// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Initiator side of the single-port BRAM request/response interface. It takes
// one load/store at a time from the core, validates alignment and size, and
// issues a single-cycle mem_read/mem_write pulse with the word address, byte
// enables and lane-replicated store data. It then waits for mem_resp, or gives
// up after TIMEOUT_CYCLES, and returns one completion pulse to the core with
// sign/zero-extended load data or an error flag.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid / req_ready    core request handshake (ready only in IDLE)
//   req_we, req_size,        access kind: store/load, 00 byte / 01 half /
//   req_unsigned             10 word / 11 illegal, zero-extend loads
//   req_addr, req_wdata      byte address, right-justified store data
//   rsp_valid, rsp_rdata,    one-cycle completion with load data and error
//   rsp_err
//   mem_read, mem_write      request pulses toward the memory
//   mem_addr, mem_wdata,     word address, replicated store data, byte
//   mem_be                   enables (held until the next request)
//   mem_rdata, mem_resp      memory response
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       lane_q, lane_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  // Request decode: misaligned halves/words and size 11 never reach memory.
  logic        req_illegal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    st_be    = 4'hF;
    st_wdata = req_wdata;
    unique case (req_size)
      2'b00: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << req_addr[1:0];
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign req_illegal = (req_size == 2'b11)
                     || ((req_size == 2'b01) && req_addr[0])
                     || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Load extraction from the lane recorded at accept time.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
  assign ld_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = mem_rdata;
    unique case (size_q)
      2'b00:   ld_data = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    // Pulses and the response registers default low/zero every cycle.
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d   = req_we;
          size_d = req_size;
          uns_d  = req_unsigned;
          lane_d = req_addr[1:0];
          if (req_illegal) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            // Address/data/enables only change when a request is issued.
            state_d     = S_ISSUE;
            mem_read_d  = !req_we;
            mem_write_d = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = req_we ? st_be : 4'h0;
            mem_wdata_d = st_wdata;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A response in the timeout cycle still wins.
        if (mem_resp) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;  // S_RESP
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Drives mem_access_unit against a behavioural BRAM that answers two cycles
// after each request pulse for addresses below MAP_BYTES and never answers
// above. Expected results come from a byte-addressed reference memory and the
// access rules (alignment, extension, lane replication).
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int T         = 16;
  localparam int MAP_BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_resp = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory contents as seen by the behavioural BRAM, and as the reference.
  logic [31:0] hw_mem   [MAP_BYTES/4];
  logic [7:0]  ref_bytes[MAP_BYTES];

  // Behavioural BRAM: request seen in cycle n, response driven in cycle n+2.
  logic        pend1 = 1'b0, pend2 = 1'b0;
  logic [31:0] pdata1 = 32'h0, pdata2 = 32'h0;

  initial begin
    forever begin
      @(negedge clk);
      mem_resp  = pend2;
      mem_rdata = pend2 ? pdata2 : $urandom();
      pend2     = pend1;
      pdata2    = pdata1;
      pend1     = 1'b0;
      if ((mem_read || mem_write) && (mem_addr < MAP_BYTES)) begin
        pend1  = 1'b1;
        pdata1 = hw_mem[mem_addr[11:2]];
        if (mem_write) begin
          for (int j = 0; j < 4; j++)
            if (mem_be[j]) hw_mem[mem_addr[11:2]][8*j +: 8] = mem_wdata[8*j +: 8];
          pdata1 = $urandom();
        end
      end
    end
  end

  // Reference model of the access rules.
  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic ref_illegal(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr);
    logic [31:0] v;
    int n;
    n = nbytes(size);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[addr + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  // Runs one access and checks response, issued request and protocol.
  task automatic do_and_check(input vec_t v, input string tag);
    int lat, n_rd, n_wr, n_viol;
    logic [31:0] got_rdata, got_addr, got_wdata;
    logic [3:0]  got_be;
    logic got_err, prev_pulse, legal, mapped;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int n;
    lat = -1; n_rd = 0; n_wr = 0; n_viol = 0; prev_pulse = 1'b0;
    got_rdata = 32'h0; got_err = 1'b0; got_addr = 32'h0; got_wdata = 32'h0; got_be = 4'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    for (int k = 1; k <= T + 8; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if ((mem_read && mem_write) || ((mem_read || mem_write) && prev_pulse)) n_viol++;
      if (mem_read || mem_write) begin
        if (mem_read) n_rd++;
        if (mem_write) n_wr++;
        got_addr = mem_addr; got_be = mem_be; got_wdata = mem_wdata;
      end
      prev_pulse = mem_read || mem_write;
      if (rsp_valid) begin
        lat = k; got_rdata = rsp_rdata; got_err = rsp_err;
        break;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(v.exp_lat));
    check({tag, ".err"}, 32'(got_err), 32'(v.exp_err));
    check({tag, ".rdata"}, got_rdata, v.exp_rdata);
    legal  = !ref_illegal(v.size, v.addr);
    mapped = v.addr < MAP_BYTES;
    check({tag, ".n_read"}, 32'(n_rd), 32'(legal && !v.we));
    check({tag, ".n_write"}, 32'(n_wr), 32'(legal && v.we));
    check({tag, ".proto"}, 32'(n_viol), 32'h0);
    if (legal) begin
      n = nbytes(v.size);
      exp_be = 4'h0;
      exp_wdata = 32'h0;
      for (int j = 0; j < 4; j++) begin
        exp_wdata[8*j +: 8] = v.wdata[8*(j % n) +: 8];
        if (v.we && j >= int'(v.addr[1:0]) && j < int'(v.addr[1:0]) + n) exp_be[j] = 1'b1;
      end
      check({tag, ".mem_addr"}, got_addr, v.addr & 32'hFFFF_FFFC);
      check({tag, ".mem_be"}, 32'(got_be), 32'(exp_be));
      if (v.we) check({tag, ".mem_wdata"}, got_wdata, exp_wdata);
      if (v.we && mapped)
        for (int i = 0; i < n; i++) ref_bytes[v.addr + i] = v.wdata[8*i +: 8];
    end
    @(negedge clk);
    check({tag, ".rsp_clear"}, {rsp_rdata[30:0], rsp_err}, 32'h0);
    check({tag, ".rsp_valid_clear"}, 32'(rsp_valid), 32'h0);
  endtask

  vec_t vecs[16];

  initial begin
    vec_t rv;
    int seen_valid, seen_pulse;

    for (int w = 0; w < MAP_BYTES / 4; w++) hw_mem[w] = $urandom();
    hw_mem[32'h10 >> 2] = 32'hDEADBEEF;
    hw_mem[32'h20 >> 2] = 32'h55667788;
    for (int b = 0; b < MAP_BYTES; b++) ref_bytes[b] = hw_mem[b / 4][8*(b % 4) +: 8];

    //           we    size   uns   addr        wdata          err  lat    rdata
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h10,     32'h0,         1'b0, 4,     32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h13,     32'h0,         1'b0, 4,     32'hFFFFFFDE};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h13,     32'h0,         1'b0, 4,     32'h000000DE};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h12,     32'h0,         1'b0, 4,     32'hFFFFDEAD};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h10,     32'h0,         1'b0, 4,     32'h0000BEEF};
    vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h22,     32'h1234ABCD,  1'b0, 4,     32'h0};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h20,     32'h0,         1'b0, 4,     32'hABCD7788};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h31,     32'hFFFFFFA5,  1'b0, 4,     32'h0};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 32'h31,     32'h0,         1'b0, 4,     32'h000000A5};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h102,    32'h0,         1'b1, 1,     32'h0};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h101,    32'h0,         1'b1, 1,     32'h0};
    vecs[11] = '{1'b0, 2'b11, 1'b0, 32'h40,     32'h0,         1'b1, 1,     32'h0};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h4000,   32'h0,         1'b1, T + 2, 32'h0};
    vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h10,     32'h0,         1'b0, 4,     32'hDEADBEEF};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h44,     32'hCAFEF00D,  1'b0, 4,     32'h0};
    vecs[15] = '{1'b0, 2'b01, 1'b0, 32'h46,     32'h0,         1'b0, 4,     32'hFFFFCAFE};

    // Reset state.
    #12;
    check("reset.ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.outputs", {mem_read, mem_write, mem_be, rsp_valid, rsp_err}, 32'h0);
    check("reset.buses", mem_addr | mem_wdata | rsp_rdata, 32'h0);
    check("reset.ready_after", 32'(req_ready), 32'h1);

    foreach (vecs[i]) do_and_check(vecs[i], $sformatf("vec%0d", i));

    // Reset while waiting for the response; the stale response must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_wait.issued", 32'(mem_read), 32'h1);
    @(negedge clk);
    check("rst_wait.in_wait", 32'(req_ready), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_wait.outputs", {mem_read, mem_write, mem_be, rsp_valid, rsp_err}, 32'h0);
    check("rst_wait.buses", mem_addr | mem_wdata | rsp_rdata, 32'h0);
    check("rst_wait.ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen_valid = 0; seen_pulse = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen_valid++;
      if (mem_read || mem_write) seen_pulse++;
    end
    check("rst_wait.no_stale_rsp", 32'(seen_valid), 32'h0);
    check("rst_wait.no_pulse", 32'(seen_pulse), 32'h0);
    check("rst_wait.ready_after", 32'(req_ready), 32'h1);
    do_and_check(vecs[13], "after_reset");

    // Randomised accesses against the reference model.
    for (int i = 0; i < 80; i++) begin
      rv.we    = 1'($urandom_range(0, 1));
      rv.size  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rv.uns   = 1'($urandom_range(0, 1));
      rv.wdata = $urandom();
      if ($urandom_range(0, 19) == 0) rv.addr = 32'h0001_0000 + (32'($urandom_range(0, 1023)) << 2);
      else                            rv.addr = 32'($urandom_range(0, MAP_BYTES - 1));
      if (ref_illegal(rv.size, rv.addr)) begin
        rv.exp_err = 1'b1; rv.exp_lat = 1; rv.exp_rdata = 32'h0;
      end else if (rv.addr >= MAP_BYTES) begin
        rv.exp_err = 1'b1; rv.exp_lat = T + 2; rv.exp_rdata = 32'h0;
      end else begin
        rv.exp_err = 1'b0; rv.exp_lat = 4;
        rv.exp_rdata = rv.we ? 32'h0 : ref_load(rv.size, rv.uns, rv.addr);
      end
      do_and_check(rv, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the single-port memory request/response interface (mem_read/mem_write/mem_addr/mem_wdata/mem_be -> mem_rdata/mem_resp) used by the core's BRAM memory.
- Accepts one load/store at a time from the core datapath.
- Checks alignment, generates the word address, byte enables and lane-replicated store data, and issues a single-cycle request pulse.
- Waits for mem_resp, then sign/zero-extends load data.
- Reports misaligned, illegal-size and timed-out (unmapped) accesses as errors.

Parameters:
TIMEOUT_CYCLES, 16, WAIT-state cycles without mem_resp before the access is failed; must be >= 2.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core access request
req_ready  output  1  high in IDLE; request accepted when req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  zero-extend load (LBU/LHU)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  valid with rsp_valid; misaligned, illegal size or timeout
mem_read  output  1  read request pulse
mem_write  output  1  write request pulse
mem_addr  output  32  {addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_be  output  4  byte enables; 4'h0 for loads
mem_rdata  input  32  read data, valid while mem_resp high
mem_resp  input  1  response, two cycles after the request pulse

Behaviour:
- Reset (async, rst_n low): state IDLE; mem_read, mem_write, mem_addr, mem_wdata, mem_be, rsp_valid, rsp_rdata and rsp_err are all 0. req_ready = (state == IDLE), so it is 1 after reset. An in-flight access is dropped. A late mem_resp arriving in IDLE is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, on accept: latch we, size, unsigned, addr[1:0] and wdata.
  - Illegal access (size == 11, half with addr[0] == 1, or word with addr[1:0] != 0): go to RESP with err = 1. No memory request is issued.
  - Otherwise: go to ISSUE.
- ISSUE (exactly one cycle): mem_read = !we, mem_write = we; mem_addr, mem_be and mem_wdata are driven. Next state WAIT; the timeout counter clears to 0. mem_addr, mem_wdata and mem_be hold their values until the next ISSUE.
- WAIT:
  - mem_resp high: capture the extended mem_rdata (stores capture 0), go to RESP with err = 0.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without mem_resp, go to RESP with err = 1 and rdata = 0.
  - mem_resp in the same cycle as the timeout: the response wins (err = 0).
- RESP (one cycle): rsp_valid = 1 with the registered rsp_rdata and rsp_err; next state IDLE. rsp_valid, rsp_rdata and rsp_err return to 0 in the following cycle.
- Latency:
  - Good access accepted in cycle 0: mem_read/mem_write in cycle 1, mem_resp in cycle 3, rsp_valid in cycle 4.
  - Illegal access: rsp_valid in cycle 1.
  - Timeout: rsp_valid in cycle 2+TIMEOUT_CYCLES.
- Store encoding, with lane = addr[1:0]:
  - byte: mem_be = 4'b0001 << lane; mem_wdata = {4{wdata[7:0]}}.
  - half: mem_be = 4'b0011 << lane; mem_wdata = {2{wdata[15:0]}}.
  - word: mem_be = 4'hF; mem_wdata = wdata.
- Load extraction:
  - byte: mem_rdata[8*lane +: 8].
  - half: mem_rdata[16*addr[1] +: 16].
  - Sign-extend unless unsigned. Word loads pass through.
- mem_read and mem_write are never both high, and are never high for more than one consecutive cycle.
- req_valid outside IDLE is ignored; the core must hold the request until it sees req_ready.

Test Plan:
- Memory word 0x10 = 0xDEADBEEF; LW addr 0x10 -> one-cycle mem_read with mem_addr 0x10 and mem_be 0; rsp_valid 4 cycles after accept with rdata 0xDEADBEEF, err 0.
- Same word, LB addr 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE. LH 0x12 -> 0xFFFFDEAD. LHU 0x10 -> 0x0000BEEF.
- SH addr 0x22, wdata 0x1234ABCD -> mem_write for one cycle, mem_addr 0x20, mem_be 4'b1100, mem_wdata 0xABCDABCD. A following LW 0x20 returns 0xABCDxxxx, with the lower half unchanged.
- LW 0x102, LH 0x101, and size 11 -> rsp_valid one cycle after accept with err 1 and rdata 0; mem_read and mem_write stay 0 throughout.
- LW 0x4000 (unmapped, no mem_resp) -> rsp_valid with err 1 exactly 2+TIMEOUT_CYCLES cycles after accept; the next access completes normally.
- Assert rst_n low during WAIT -> all outputs 0 immediately and req_ready = 1 after release. The stale mem_resp arriving after release produces no rsp_valid.
